// File: rtl/axi_read_burst_splitter_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_read_burst_splitter_if
// Description : Bundles the command-side handshake and the AXI read-address
//               signals of the read burst splitter.
//               modport master - the splitter. It takes the command and
//                                arready, and drives cmd_ready, AR*, busy
//                                and done.
//               modport slave  - the command source plus the AR sink.
//               Signals:
//                 cmd_valid/cmd_ready/cmd_addr[AW]/cmd_beats[16]
//                 araddr[AW]/arlen[8]/arsize[3]/arburst[2]/arvalid/arready
//                 busy/done
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_read_burst_splitter_if #(
    parameter int AW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [15:0]   cmd_beats;

    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;

    logic          busy;
    logic          done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_beats, arready,
        output cmd_ready, araddr, arlen, arsize, arburst, arvalid, busy, done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_beats, arready,
        input  cmd_ready, araddr, arlen, arsize, arburst, arvalid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/axi_read_burst_splitter.sv
`default_nettype none
// ============================================================================
// Module      : axi_read_burst_splitter
// Description : Accepts one read command (start address and a count of 8-byte
//               beats) and splits it into AXI INCR bursts. Each burst is at
//               most MAX_BEATS beats long and never crosses a 4 KB boundary.
//               Ports:
//                 clk  - single rising-edge clock
//                 rst  - asynchronous, active-high reset
//                 bus  - axi_read_burst_splitter_if.master
//                        (command handshake, AR channel, busy, done)
//               Parameters:
//                 AW        - address width (>= 12); must match the width
//                             of the interface instance
//                 MAX_BEATS - beats per burst cap, a power of two in 1..256
// Revision    : 1.0 - initial release
// ============================================================================
module axi_read_burst_splitter #(
    parameter int AW        = 32,
    parameter int MAX_BEATS = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    axi_read_burst_splitter_if.master bus
);

    generate
        if (MAX_BEATS < 1 || MAX_BEATS > 256 || (MAX_BEATS & (MAX_BEATS - 1)) != 0) begin : g_bad_max_beats
            $error("axi_read_burst_splitter: MAX_BEATS must be a power of two in 1..256");
        end
        if (AW < 12) begin : g_bad_aw
            $error("axi_read_burst_splitter: AW must be at least 12");
        end
    endgenerate

    localparam logic [15:0]   c_max_beats = 16'(MAX_BEATS);
    localparam logic [2:0]    c_arsize    = 3'b011;
    localparam logic [1:0]    c_arburst   = 2'b01;
    localparam logic [AW-1:0] c_addr_mask = {{(AW-3){1'b1}}, 3'b000};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_addr,   w_addr_nxt;     // start of the next burst
    logic [15:0]   r_rem,    w_rem_nxt;      // beats not yet issued
    logic [8:0]    r_n,      w_n_nxt;        // length of the burst on the bus
    logic [AW-1:0] r_araddr, w_araddr_nxt;
    logic [7:0]    r_arlen,  w_arlen_nxt;
    logic          r_done,   w_done_nxt;
    // Holds cmd_ready low during reset and until the first edge after release.
    logic          r_live;

    logic [12:0]   w_span;
    logic [9:0]    w_to4k;
    logic [15:0]   w_lim;
    logic [8:0]    w_n;
    logic [8:0]    w_n_m1;
    logic          w_cmd_ready;

    // Beats left before the next 4 KB boundary: 1..512.
    assign w_span = 13'h1000 - {1'b0, r_addr[11:0]};
    assign w_to4k = 10'(w_span >> 3);

    // n = min(rem, MAX_BEATS, to4k). The result never exceeds MAX_BEATS, so
    // 9 bits hold it.
    always_comb begin
        w_lim = (r_rem < c_max_beats) ? r_rem : c_max_beats;
        if ({6'd0, w_to4k} < w_lim) begin
            w_lim = {6'd0, w_to4k};
        end
        w_n    = 9'(w_lim);
        w_n_m1 = w_n - 9'd1;
    end

    assign w_cmd_ready = r_live && (r_state == S_IDLE);

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_rem_nxt    = r_rem;
        w_n_nxt      = r_n;
        w_araddr_nxt = r_araddr;
        w_arlen_nxt  = r_arlen;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid && w_cmd_ready) begin
                    w_addr_nxt = bus.cmd_addr & c_addr_mask;
                    w_rem_nxt  = bus.cmd_beats;
                    if (bus.cmd_beats == 16'd0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_CALC;
                    end
                end
            end
            S_CALC: begin
                w_araddr_nxt = r_addr;
                w_arlen_nxt  = w_n_m1[7:0];
                w_n_nxt      = w_n;
                w_state_nxt  = S_ISSUE;
            end
            S_ISSUE: begin
                if (bus.arready) begin
                    w_addr_nxt = r_addr + AW'({r_n, 3'b000});
                    w_rem_nxt  = r_rem - {7'd0, r_n};
                    if (r_rem == {7'd0, r_n}) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_CALC;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_rem    <= '0;
            r_n      <= '0;
            r_araddr <= '0;
            r_arlen  <= '0;
            r_done   <= 1'b0;
            r_live   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_rem    <= w_rem_nxt;
            r_n      <= w_n_nxt;
            r_araddr <= w_araddr_nxt;
            r_arlen  <= w_arlen_nxt;
            r_done   <= w_done_nxt;
            r_live   <= 1'b1;
        end
    end

    // arvalid and busy decode the asynchronously reset state, so they fall
    // as soon as rst rises. arvalid does not depend on arready.
    assign bus.cmd_ready = w_cmd_ready;
    assign bus.arvalid   = (r_state == S_ISSUE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.araddr    = r_araddr;
    assign bus.arlen     = r_arlen;
    assign bus.arsize    = c_arsize;
    assign bus.arburst   = c_arburst;

endmodule
`default_nettype wire

// File: doc/axi_read_burst_splitter.md
# axi_read_burst_splitter

Upstream command stage for the AXI read channel. Accepts one read command (start address plus a count of 64-bit beats) and splits it into legal AXI INCR bursts. Each burst is capped at MAX_BEATS and never crosses a 4 KB boundary. The bursts drive the read-address inputs (araddr/arlen/arsize/arburst/arvalid) of the master/slave read-channel pair, and the stage waits on that pair's arready.

## Interface
- AW, 32, address width.
- MAX_BEATS, 16, maximum beats per burst; power of two, 1..256; anything else is an elaboration error.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  stage can accept a command.
- cmd_addr  in  AW  start byte address; bits [2:0] are ignored and forced to zero.
- cmd_beats  in  16  number of 8-byte beats; 0 is a legal no-op.
- araddr  out  AW  burst start address.
- arlen  out  8  beats minus one.
- arsize  out  3  constant 3'b011 (8 bytes).
- arburst  out  2  constant 2'b01 (INCR).
- arvalid  out  1  burst request valid.
- arready  in  1  downstream accepts the burst.
- busy  out  1  a command is in progress (state is not IDLE).
- done  out  1  one-cycle pulse; the command has fully issued.

## Operation
- FSM states: IDLE, CALC, ISSUE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch addr_q={cmd_addr[AW-1:3],3'b0} and rem_q=cmd_beats.
  - If cmd_beats==0: stay IDLE and pulse done on the next cycle.
  - Otherwise go to CALC.
- CALC (one cycle, arvalid=0):
  - to4k = (4096 - addr_q[11:0]) >> 3, range 1..512.
  - n = min(rem_q, MAX_BEATS, to4k).
  - Register araddr=addr_q and arlen=n-1 (8-bit), and hold n in n_q.
  - Go to ISSUE.
- ISSUE:
  - arvalid=1; araddr and arlen are held stable until arvalid&arready.
  - On handshake: addr_q += n_q<<3 (modulo 2^AW) and rem_q -= n_q.
  - If the new rem_q==0: go to IDLE and pulse done.
  - Otherwise go to CALC.
- Arithmetic widths: rem_q is 16 bits, n_q is 9 bits, to4k is 10 bits. No subtraction underflows, because n ≤ rem_q.
- Address wrap past 2^AW-1 is silent modulo wrap. A burst itself cannot wrap, because 4 KB splitting happens first.
- done and the return of cmd_ready coincide. A new command may be accepted in the same cycle done is high.
- cmd_ready is 0 in CALC and ISSUE; commands presented then are not taken.
- busy=1 in CALC and ISSUE.

## Timing
- Reset values:
  - state=IDLE.
  - arvalid=0, araddr=0, arlen=0, done=0, busy=0.
  - arsize and arburst are constant even during reset.
  - cmd_ready=0 while rst is high; it rises on the first clk edge after release.
- Assertion of rst clears arvalid, busy and done immediately, without waiting for clk.
- Reset mid-command discards the command; no residual bursts are issued after release. The downstream read channel shares the reset domain.
- Latency: a command accepted at edge E0 gives CALC during cycle 1 and arvalid high from cycle 2.
- Between bursts there is exactly one arvalid=0 cycle (CALC).
- Burst throughput: one burst per 2 cycles when arready is held high.
- done is asserted in the cycle after the final AR handshake.
- arvalid never drops without a handshake, except on reset.
- Per AXI, arvalid does not depend on arready.

## Test plan
- MAX_BEATS=16, cmd 0x1000 / 16 beats, arready=1 → one burst: araddr=0x1000, arlen=15. done high 1 cycle later; cmd_ready is 1 that cycle.
- cmd 0x0FC0 / 20 beats → 4 KB split:
  - burst 0x0FC0 arlen=7;
  - then 0x1000 arlen=11;
  - no burst crosses 0x1000;
  - done after the second burst.
- cmd 0x2003 / 40 beats, MAX_BEATS=16 → bursts 0x2000/15, 0x2080/15, 0x2100/7, with one arvalid-low cycle between each.
- arready held low for 5 cycles in ISSUE → arvalid stays 1 and araddr/arlen are unchanged for all 5 cycles. The handshake happens on the 6th cycle, and state advances.
- cmd_beats=0 → arvalid never asserts; done pulses the cycle after accept; busy stays 0.
- rst pulsed while arvalid=1 during the second of three bursts:
  - arvalid and busy drop to 0 asynchronously;
  - cmd_ready is 1 one edge after release;
  - no further bursts until a new command.
